// File: rtl/be_word_packer.sv
// Byte-stream to 32-bit word packer: fills byte lanes in order, then writes the word
// with byte enables to a RAM port one cycle after the completing byte is accepted.
module be_word_packer #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [3:0]        wr_be,
    output logic              done,
    output logic [ADDR_W:0]   word_cnt,
    output logic              wrap_err
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    localparam logic [ADDR_W:0] CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_t            state, state_next;
    logic [ADDR_W-1:0] addr_ptr;
    logic [1:0]        lane_ptr;
    logic [31:0]       acc;
    logic [3:0]        acc_be;

    logic              accept;
    logic              complete;
    logic [31:0]       word_next;
    logic [3:0]        be_next;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        accept     = (state == ACTIVE) && in_valid;
        complete   = accept && ((lane_ptr == 2'd3) || in_last);
        word_next  = acc;
        word_next[{lane_ptr, 3'b000} +: 8] = in_data;
        be_next    = acc_be | (4'b0001 << lane_ptr);

        case (state)
            IDLE:    if (start) state_next = ACTIVE;
            ACTIVE:  if (complete && in_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign in_ready = (state == ACTIVE);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_ptr <= '0;
            lane_ptr <= '0;
            acc      <= '0;
            acc_be   <= '0;
            word_cnt <= '0;
            wrap_err <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_be    <= '0;
            done     <= 1'b0;
        end else begin
            // The write port is a one-cycle strobe; data and enables read zero when idle.
            wr_en   <= 1'b0;
            wr_data <= '0;
            wr_be   <= '0;
            done    <= 1'b0;

            if ((state == IDLE) && start) begin
                addr_ptr <= base_addr;
                lane_ptr <= '0;
                acc      <= '0;
                acc_be   <= '0;
                word_cnt <= '0;
                wrap_err <= 1'b0;
            end else if (accept) begin
                if (complete) begin
                    wr_en    <= 1'b1;
                    wr_addr  <= addr_ptr;
                    wr_data  <= word_next;
                    wr_be    <= be_next;
                    done     <= in_last;
                    // Clearing the lane state on this edge keeps full byte-per-cycle throughput.
                    acc      <= '0;
                    acc_be   <= '0;
                    lane_ptr <= '0;
                    addr_ptr <= addr_ptr + 1'b1;
                    if (addr_ptr == {ADDR_W{1'b1}}) wrap_err <= 1'b1;
                    if (word_cnt != CNT_MAX) word_cnt <= word_cnt + 1'b1;
                end else begin
                    acc      <= word_next;
                    acc_be   <= be_next;
                    lane_ptr <= lane_ptr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_be_word_packer.sv
// Self-checking bench for be_word_packer: expected writes are derived per packet by
// chunking the byte list into 4-byte words at consecutive (modulo) addresses.
module tb_be_word_packer;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_be;
    logic              done;
    logic [ADDR_W:0]   word_cnt;
    logic              wrap_err;

    int tests = 0;
    int fails = 0;
    byte unsigned pkt[$];

    be_word_packer #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base_addr(base_addr),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .done     (done),
        .word_cnt (word_cnt),
        .wrap_err (wrap_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_no_write(input string tag);
        check({tag, "_wr_en"},   wr_en,   0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_wr_be"},   wr_be,   0);
        check({tag, "_done"},    done,    0);
    endtask

    // Runs one packet from pkt[]; restart_at >= 0 pulses start mid-packet with another base.
    task automatic run_packet(input int base, input bit toggle, input int restart_at,
                              input int restart_base);
        int n      = pkt.size();
        int nwords = (n + 3) / 4;
        int idx    = 0;
        int cyc    = 0;
        bit v;
        int w;
        logic [31:0] exp_data;
        logic [3:0]  exp_be;

        // Byte presented with start must not be accepted.
        start     = 1'b1;
        base_addr = ADDR_W'(base);
        in_valid  = 1'b1;
        in_data   = 8'hEE;
        in_last   = 1'b1;
        tick();
        start = 1'b0;
        check("ready_after_start", in_ready, 1);
        check_no_write("start_cycle");
        check("cnt_clear_on_start", word_cnt, 0);
        check("wrap_clear_on_start", wrap_err, 0);

        while (idx < n && cyc < 4 * n + 20) begin
            v         = toggle ? (cyc % 2 == 0) : 1'b1;
            in_valid  = v;
            in_data   = v ? pkt[idx] : 8'($urandom);
            in_last   = v ? (idx == n - 1) : 1'($urandom);
            start     = (cyc == restart_at);
            base_addr = ADDR_W'(restart_base);
            check("in_ready_active", in_ready, 1);
            tick();
            cyc++;
            start = 1'b0;
            if (v) begin
                idx++;
                if (idx % 4 == 0 || idx == n) begin
                    w        = (idx - 1) / 4;
                    exp_data = '0;
                    exp_be   = '0;
                    for (int k = 0; k < 4; k++) begin
                        if (4 * w + k < n) begin
                            exp_data[8*k +: 8] = pkt[4*w+k];
                            exp_be[k]          = 1'b1;
                        end
                    end
                    check("wr_en",    wr_en,    1);
                    check("wr_addr",  wr_addr,  (base + w) % DEPTH);
                    check("wr_data",  wr_data,  exp_data);
                    check("wr_be",    wr_be,    exp_be);
                    check("done",     done,     idx == n);
                    check("word_cnt", word_cnt, (w + 1 < DEPTH) ? w + 1 : DEPTH);
                end else begin
                    check_no_write("mid_word");
                end
            end else begin
                check_no_write("gap_cycle");
            end
        end
        if (idx < n) check("packet_timeout", idx, n);

        in_valid = 1'b0;
        in_last  = 1'b0;
        check("idle_after_last", in_ready, 0);
        check("wrap_err_end", wrap_err, (base + nwords) >= DEPTH);
        tick();
        check_no_write("after_packet");
    endtask

    task automatic random_packet(input int len);
        pkt.delete();
        for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check_no_write("rst");
        check("rst_wr_addr", wr_addr, 0);
        check("rst_word_cnt", word_cnt, 0);
        check("rst_wrap_err", wrap_err, 0);
        rst_n = 1'b1;

        // Bytes offered while idle are ignored.
        in_valid = 1'b1;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'($urandom);
            tick();
            check("idle_in_ready", in_ready, 0);
            check_no_write("idle_valid");
        end
        in_valid = 1'b0;
        in_last  = 1'b0;

        pkt = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_packet(5, 1'b0, -1, 0);

        pkt = '{8'hAA, 8'hBB, 8'hCC};
        run_packet(10, 1'b0, -1, 0);

        random_packet(8);
        run_packet(63, 1'b0, -1, 0);

        // Single byte packet; its start also clears the sticky wrap flag.
        random_packet(1);
        run_packet(2, 1'b0, -1, 0);

        random_packet(4);
        run_packet(17, 1'b1, -1, 0);

        // Reset after two bytes, with a completing byte pending at the reset edge.
        start     = 1'b1;
        base_addr = ADDR_W'(20);
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = 8'($urandom);
            tick();
        end
        in_last = 1'b1;
        rst_n   = 1'b0;
        tick();
        check("midrst_in_ready", in_ready, 0);
        check_no_write("midrst");
        check("midrst_wr_addr", wr_addr, 0);
        check("midrst_word_cnt", word_cnt, 0);
        check("midrst_wrap_err", wrap_err, 0);
        rst_n = 1'b1;
        tick();
        check_no_write("post_rst");
        in_valid = 1'b0;
        in_last  = 1'b0;
        random_packet(3);
        run_packet(7, 1'b0, -1, 0);

        random_packet(12);
        run_packet(30, 1'b0, 3, 50);

        for (int p = 0; p < 6; p++) begin
            random_packet($urandom_range(20, 1));
            run_packet($urandom_range(DEPTH - 1, 0), 1'($urandom), -1, 0);
        end

        // Long packet: wraps the address and saturates word_cnt.
        random_packet(4 * (DEPTH + 2));
        run_packet(40, 1'b0, -1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/be_word_packer.md
BE_WORD_PACKER -- requirements
Module: be_word_packer

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, RAM word-address width (64 words).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  one-cycle pulse that begins a packet.
REQ-005 SHALL have port base_addr  input  ADDR_W  first word address, sampled with start.
REQ-006 SHALL have port in_data  input  8  stream byte.
REQ-007 SHALL have port in_valid  input  1  in_data/in_last valid.
REQ-008 SHALL have port in_last  input  1  marks the final byte of the packet.
REQ-009 SHALL have port in_ready  output  1  byte accepted when in_valid & in_ready.
REQ-010 SHALL have port wr_en  output  1  RAM port write strobe (drives we).
REQ-011 SHALL have port wr_addr  output  ADDR_W  RAM word address.
REQ-012 SHALL have port wr_data  output  32  packed word; byte k on bits [8k+7:8k].
REQ-013 SHALL have port wr_be  output  4  byte enables; bit k qualifies byte k.
REQ-014 SHALL have port done  output  1  one-cycle pulse on the final write of a packet.
REQ-015 SHALL have port word_cnt  output  ADDR_W+1  words written in the current packet.
REQ-016 SHALL have port wrap_err  output  1  sticky flag: address wrapped during the packet.

Function
REQ-017 SHALL implement the FSM states IDLE and ACTIVE; in_ready = 1 only in ACTIVE.
REQ-018 IDLE: start SHALL load the address pointer from base_addr, clear word_cnt, wrap_err, lane pointer and accumulator, then enter ACTIVE next cycle; bytes presented in the start cycle SHALL NOT be accepted.
REQ-019 start in ACTIVE SHALL be ignored.
REQ-020 Each accepted byte SHALL be stored in accumulator lane lane_ptr (0..3), set that lane's enable bit, and advance lane_ptr.
REQ-021 Accepting a byte in lane 3, or any byte with in_last=1, SHALL complete the word.
REQ-022 On the cycle after completion: wr_en=1; wr_addr=pointer; wr_data=accumulator with unfilled lanes = 0x00; wr_be=the filled-lane mask (lanes 0..n-1 contiguous).
REQ-023 Write latency SHALL be exactly 1 cycle from the accepting edge; wr_en SHALL be high for exactly one cycle per word.
REQ-024 On completion, the accumulator and lane_ptr SHALL clear in the same edge, so a byte in the very next cycle starts a new word at lane 0 with no stall (full throughput of 1 byte/cycle).
REQ-025 After each write, the pointer SHALL increment modulo 2^ADDR_W and word_cnt SHALL increment.
REQ-026 A wrap of the pointer from 2^ADDR_W-1 to 0 SHALL set wrap_err, which SHALL hold until the next accepted start or reset; writes SHALL continue at address 0.
REQ-027 word_cnt SHALL saturate at 2^ADDR_W.
REQ-028 A completion with in_last=1 SHALL return the FSM to IDLE on the accepting edge; done SHALL be asserted together with that word's wr_en.
REQ-029 When wr_en=0, wr_data and wr_be SHALL be 0.
REQ-030 A packet of a single byte SHALL produce one write with wr_be=0001.
REQ-031 in_valid in IDLE SHALL be ignored, with no state change.

Reset
REQ-032 rst_n=0 at a rising edge SHALL force: IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, wr_be=0, done=0, word_cnt=0, wrap_err=0, lane_ptr=0, accumulator=0.
REQ-033 Reset mid-packet SHALL discard the partial word; no write SHALL issue after reset, including a completion pending from the reset cycle.

Verification
REQ-034 start, base_addr=5; bytes 11,22,33,44,55,66,77,88 back-to-back, last on 88 -> writes addr5 data 0x44332211 be 1111, then addr6 data 0x88776655 be 1111 with done; word_cnt=2.
REQ-035 base_addr=10; bytes AA,BB,CC, last on CC -> single write addr10 data 0x00CCBBAA be 0111, done=1.
REQ-036 base_addr=63; 8 bytes -> writes at 63 then 0, wrap_err=1 after the second write; next start clears it.
REQ-037 in_valid toggled 1/0 every cycle over 4 bytes -> exactly one write, 1 cycle after the 4th byte is accepted; in_ready stays 1 throughout.
REQ-038 rst_n pulsed low after 2 of 4 bytes -> no wr_en; all outputs 0; a following packet starts at lane 0.
REQ-039 start pulsed while ACTIVE with a different base_addr -> ignored; addresses continue sequentially.
